// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control with a mul/div busy FSM and performance counters
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_stall_i,
    input  logic        dcache_stall_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rd_i,
    input  logic [4:0]  ifid_rs1_i,
    input  logic [4:0]  ifid_rs2_i,
    input  logic        mispredict_i,
    input  logic        muldiv_req_i,
    output logic        pc_write_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_stall_o,
    output logic        idex_flush_o,
    output logic        exmem_stall_o,
    output logic        memwb_stall_o,
    output logic        muldiv_busy_o,
    output logic        muldiv_done_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);
    typedef enum logic [1:0] {RUN, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        mem_stall, freeze, load_use;

    assign mem_stall = icache_stall_i | dcache_stall_i;
    assign freeze    = mem_stall | ((state_q == RUN) & muldiv_req_i) | (state_q == BUSY);
    assign load_use  = idex_memread_i & (idex_rd_i != 5'd0) &
                       ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

    // Pipeline controls: reset, then freeze, then mispredict, then load-use
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_stall_o = 1'b0;
        memwb_stall_o = 1'b0;
        if (rst) begin
            pc_write_o   = 1'b0;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (freeze) begin
            pc_write_o    = 1'b0;
            ifid_stall_o  = 1'b1;
            idex_stall_o  = 1'b1;
            exmem_stall_o = 1'b1;
            memwb_stall_o = 1'b1;
        end else if (mispredict_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_write_o   = 1'b0;
            ifid_stall_o = 1'b1;
            idex_flush_o = 1'b1;
        end
    end

    assign muldiv_busy_o = !rst && (state_q == BUSY);
    assign muldiv_done_o = !rst && (state_q == DONE) && !mem_stall;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

    // Mul/div sequencing: entry deferred under memory stall, completion held until memory is ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (muldiv_req_i && !mem_stall) begin
                    state_d = BUSY;
                    cnt_d   = 6'(MULDIV_LAT - 1);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = DONE;
                    cnt_d   = 6'd0;
                end
            end
            DONE: begin
                if (!mem_stall) state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 6'd0;
            end
        endcase
        stall_cnt_d = stall_cnt_q + {31'd0, ~pc_write_o};
        flush_cnt_d = flush_cnt_q + {31'd0, ifid_flush_o};
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 6'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl with MULDIV_LAT=4
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst, icache_stall_i, dcache_stall_i, idex_memread_i, mispredict_i, muldiv_req_i;
    logic [4:0]  idex_rd_i, ifid_rs1_i, ifid_rs2_i;
    logic        pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o;
    logic        exmem_stall_o, memwb_stall_o, muldiv_busy_o, muldiv_done_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    // ctrl bits: pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_stall, busy, done
    localparam logic [8:0] N   = 9'b100000000;
    localparam logic [8:0] FR  = 9'b010101100;
    localparam logic [8:0] FRB = 9'b010101110;
    localparam logic [8:0] MP  = 9'b101010000;
    localparam logic [8:0] LU  = 9'b010010000;
    localparam logic [8:0] RS  = 9'b001010000;
    localparam logic [8:0] DN  = 9'b100000001;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] s;
        logic [31:0] f;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   step_id = 0;

    pipe_hazard_ctrl #(.MULDIV_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
        .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
        .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
        .mispredict_i(mispredict_i), .muldiv_req_i(muldiv_req_i),
        .pc_write_o(pc_write_o), .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o),
        .idex_stall_o(idex_stall_o), .idex_flush_o(idex_flush_o),
        .exmem_stall_o(exmem_stall_o), .memwb_stall_o(memwb_stall_o),
        .muldiv_busy_o(muldiv_busy_o), .muldiv_done_o(muldiv_done_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, ic, dc, mr, input logic [4:0] rd, rs1, rs2,
                        input logic mp, rq, input logic [8:0] c, input logic [31:0] s, f);
        exp_t e;
        @(negedge clk);
        rst = r; icache_stall_i = ic; dcache_stall_i = dc; idex_memread_i = mr;
        idex_rd_i = rd; ifid_rs1_i = rs1; ifid_rs2_i = rs2;
        mispredict_i = mp; muldiv_req_i = rq;
        step_id++;
        e.ctrl = c; e.s = s; e.f = f; e.id = step_id;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [31:0] s, f);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, N, s, f);
    endtask

    // Monitor: outputs are combinational, so every cycle with a pending expectation is compared
    initial begin
        exp_t e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
                       exmem_stall_o, memwb_stall_o, muldiv_busy_o, muldiv_done_o};
                checks++;
                if (act !== e.ctrl) begin
                    failures++;
                    $display("FAIL ctrl step %0d: got %b expected %b", e.id, act, e.ctrl);
                end
                checks++;
                if (stall_cnt_o !== e.s) begin
                    failures++;
                    $display("FAIL stall_cnt step %0d: got %h expected %h", e.id, stall_cnt_o, e.s);
                end
                checks++;
                if (flush_cnt_o !== e.f) begin
                    failures++;
                    $display("FAIL flush_cnt step %0d: got %h expected %h", e.id, flush_cnt_o, e.f);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, RS, 0, 0);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, RS, 0, 0);
        idle(0, 0);
        // load-use on rs2, x0 load, load-use on rs1, non-load match
        step(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 0, LU, 0, 0);
        idle(1, 0);
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, N, 1, 0);
        step(0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 0, LU, 1, 0);
        step(0, 0, 0, 0, 5'd5, 5'd1, 5'd5, 0, 0, N, 2, 0);
        // mispredict held through a 3-cycle dcache stall
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, FR, 2, 0);
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, FR, 3, 0);
        step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, FR, 4, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, MP, 5, 0);
        idle(5, 1);
        // mispredict wins over simultaneous load-use
        step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, MP, 5, 1);
        idle(5, 2);
        // uncontended mul/div, LAT=4: 5 frozen cycles, done on the 6th
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, FR, 5, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 6, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 7, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 8, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 9, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, DN, 10, 2);
        idle(10, 2);
        // mul/div with icache stall over the last BUSY cycle and DONE; request ignored in DONE
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, FR, 10, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 11, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 12, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 13, 2);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 14, 2);
        step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, FR, 15, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, DN, 16, 2);
        idle(16, 2);
        // reset mid-BUSY aborts with no done pulse and clears counters
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, FR, 16, 2);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRB, 17, 2);
        step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, RS, 18, 2);
        idle(0, 0);
        // stall counter wrap from a preloaded all-ones value
        @(negedge clk);
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        step(0, 0, 0, 1, 5'd9, 5'd9, 5'd2, 0, 0, LU, 32'hFFFF_FFFF, 0);
        idle(0, 0);
        @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
